// File: rtl/need_engine.sv
// need_engine
// Multi-channel need-level engine for the tamagotchi core. Each channel holds
// an unsigned need value that decays, receives boosts and penalties on a
// divided update tick, and saturates at 0 and MAXV. Values are quantised into
// display levels with low-level alarms, and a zero timer drives the sticky
// `expired` flag for the death path.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   decay_en[NCH]   per-channel enable of the 1-per-tick natural decay
//   inc_amt, dec_amt per-channel boost / penalty, channel i at [i*VW +: VW]
//   freeze          suspends value updates and the zero timer
//   cmd_valid/ready command handshake; ready drops on the tick cycle
//   cmd_op, cmd_ch  00 all-to-MAXV + clear expired, 01 LOWV, 10 zero, 11 MAXV
//   value, level    current values and quantised levels (packed per channel)
//   low_alarm       level <= ALARM_LVL per channel
//   expired         sticky expiry flag
module need_engine #(
  parameter int NCH       = 3,
  parameter int VW        = 8,
  parameter int MAXV      = 255,
  parameter int LOWV      = 80,
  parameter int LSTEP     = 51,
  parameter int LW        = 3,
  parameter int ALARM_LVL = 1,
  parameter int TICK_DIV  = 4,
  parameter int ZERO_HOLD = 51,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    decay_en,
  input  logic [NCH*VW-1:0] inc_amt,
  input  logic [NCH*VW-1:0] dec_amt,
  input  logic              freeze,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CW-1:0]     cmd_ch,
  output logic [NCH*VW-1:0] value,
  output logic [NCH*LW-1:0] level,
  output logic [NCH-1:0]    low_alarm,
  output logic              expired
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ZW = $clog2(ZERO_HOLD + 1);
  localparam logic signed [VW+1:0] MAXS = (VW+2)'(MAXV);
  localparam logic [LW-1:0] RST_LVL = LW'((MAXV + LSTEP - 1) / LSTEP);

  logic [TW-1:0] r_tickCnt;
  logic [ZW-1:0] r_zeroCnt;
  logic          r_expired;
  logic [VW-1:0] r_value [NCH];
  logic [LW-1:0] r_level [NCH];
  logic [NCH-1:0] r_lowAlarm;

  logic                 w_tick;
  logic                 w_accept;
  logic                 w_anyZero;
  logic signed [VW+1:0] w_sum  [NCH];
  logic [VW-1:0]        w_next [NCH];
  logic [LW-1:0]        w_lvl  [NCH];

  assign w_tick    = (r_tickCnt == TW'(TICK_DIV - 1));
  assign cmd_ready = ~w_tick;
  assign w_accept  = cmd_valid & ~w_tick;
  assign expired   = r_expired;
  assign low_alarm = r_lowAlarm;

  // Free-running tick divider; keeps counting while frozen so the tick phase
  // is never disturbed by freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  // Per-channel next value in VW+2 signed so that val+inc-dec-decay can never
  // wrap, then clamped into 0..MAXV. Also derives the zero condition and the
  // display level of the current value.
  always_comb begin
    w_anyZero = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_sum[i] = $signed({2'b00, r_value[i]})
               + $signed({2'b00, inc_amt[i*VW +: VW]})
               - $signed({2'b00, dec_amt[i*VW +: VW]})
               - $signed({{(VW+1){1'b0}}, decay_en[i]});
      if (w_sum[i] < 0) begin
        w_next[i] = '0;
      end else if (w_sum[i] > MAXS) begin
        w_next[i] = VW'(MAXV);
      end else begin
        w_next[i] = w_sum[i][VW-1:0];
      end
      if (r_value[i] == '0) begin
        w_anyZero = 1'b1;
      end
      w_lvl[i] = LW'(({1'b0, r_value[i]} + (VW+1)'(LSTEP - 1)) / (VW+1)'(LSTEP));
    end
  end

  // Value registers: an accepted command wins (it can never share a cycle
  // with a tick); otherwise an unfrozen tick applies the clamped update.
  // A cmd_ch outside 0..NCH-1 matches no channel and so has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_value[i] <= VW'(MAXV);
      end
    end else if (w_accept) begin
      for (int i = 0; i < NCH; i++) begin
        if (cmd_op == 2'b00) begin
          r_value[i] <= VW'(MAXV);
        end else if (int'(cmd_ch) == i) begin
          case (cmd_op)
            2'b01:   r_value[i] <= VW'(LOWV);
            2'b10:   r_value[i] <= '0;
            default: r_value[i] <= VW'(MAXV);
          endcase
        end
      end
    end else if (w_tick && !freeze) begin
      for (int i = 0; i < NCH; i++) begin
        r_value[i] <= w_next[i];
      end
    end
  end

  // Zero timer and sticky expiry. Qualifying ticks look at the pre-update
  // values; the counter saturates at ZERO_HOLD and expired sets on the edge
  // that completes the ZERO_HOLD-th consecutive qualifying tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zeroCnt <= '0;
      r_expired <= 1'b0;
    end else if (w_accept && cmd_op == 2'b00) begin
      r_zeroCnt <= '0;
      r_expired <= 1'b0;
    end else if (w_tick && !freeze) begin
      if (w_anyZero) begin
        if (r_zeroCnt != ZW'(ZERO_HOLD)) begin
          r_zeroCnt <= r_zeroCnt + 1'b1;
        end
        if (r_zeroCnt >= ZW'(ZERO_HOLD - 1)) begin
          r_expired <= 1'b1;
        end
      end else begin
        r_zeroCnt <= '0;
      end
    end
  end

  // Levels and alarms are registered from the value registers, so they trail
  // value by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_level[i] <= RST_LVL;
      end
      r_lowAlarm <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_level[i]    <= w_lvl[i];
        r_lowAlarm[i] <= (w_lvl[i] <= LW'(ALARM_LVL));
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    value = '0;
    level = '0;
    for (int i = 0; i < NCH; i++) begin
      value[i*VW +: VW] = r_value[i];
      level[i*LW +: LW] = r_level[i];
    end
  end

endmodule

// File: tb/tb_need_engine.sv
// tb_need_engine
// Self-checking bench for need_engine. A behavioural model (plain integer
// arithmetic on the need values, tick phase, zero count and expiry) is
// stepped on every rising edge and compared against all outputs; directed
// sequences and a table of level-boundary vectors check spec values directly.
module tb_need_engine;

  localparam int NCH       = 3;
  localparam int VW        = 8;
  localparam int MAXV      = 255;
  localparam int LOWV      = 80;
  localparam int LSTEP     = 51;
  localparam int LW        = 3;
  localparam int ALARM_LVL = 1;
  localparam int TICK_DIV  = 4;
  localparam int ZERO_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    decay_en;
  logic [NCH*VW-1:0] inc_amt;
  logic [NCH*VW-1:0] dec_amt;
  logic              freeze;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_ch;
  logic [NCH*VW-1:0] value;
  logic [NCH*LW-1:0] level;
  logic [NCH-1:0]    low_alarm;
  logic              expired;

  need_engine #(
    .NCH(NCH), .VW(VW), .MAXV(MAXV), .LOWV(LOWV), .LSTEP(LSTEP), .LW(LW),
    .ALARM_LVL(ALARM_LVL), .TICK_DIV(TICK_DIV), .ZERO_HOLD(ZERO_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .decay_en(decay_en), .inc_amt(inc_amt),
    .dec_amt(dec_amt), .freeze(freeze), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .value(value),
    .level(level), .low_alarm(low_alarm), .expired(expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int mVal[NCH];
  int mLvl[NCH];
  bit mAlarm[NCH];
  int mPhase;
  int mZero;
  bit mExp;
  bit mLastTick;
  bit mLastAcc;

  typedef struct {
    int decAmt;
    int expVal;
    int expLvl;
    int expAlarm;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] dEn, input logic [NCH*VW-1:0] incV,
                               input logic [NCH*VW-1:0] decV, input logic frz);
    decay_en = dEn;
    inc_amt  = incV;
    dec_amt  = decV;
    freeze   = frz;
  endtask

  task automatic resetModel();
    for (int i = 0; i < NCH; i++) begin
      mVal[i]   = MAXV;
      mLvl[i]   = (MAXV + LSTEP - 1) / LSTEP;
      mAlarm[i] = 1'b0;
    end
    mPhase = 0;
    mZero  = 0;
    mExp   = 1'b0;
  endtask

  // One rising edge of the reference model, using the inputs present at the edge.
  task automatic modelEdge();
    bit tick;
    bit anyZero;
    int n;
    tick = (mPhase == TICK_DIV - 1);
    anyZero = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      mLvl[i]   = (mVal[i] + LSTEP - 1) / LSTEP;
      mAlarm[i] = (mLvl[i] <= ALARM_LVL);
    end
    mLastTick = tick;
    mLastAcc  = 1'b0;
    if (cmd_valid && !tick) begin
      mLastAcc = 1'b1;
      if (cmd_op == 2'd0) begin
        for (int i = 0; i < NCH; i++) mVal[i] = MAXV;
        mZero = 0;
        mExp  = 1'b0;
      end else if (int'(cmd_ch) < NCH) begin
        mVal[cmd_ch] = (cmd_op == 2'd1) ? LOWV : (cmd_op == 2'd2) ? 0 : MAXV;
      end
    end else if (tick && !freeze) begin
      for (int i = 0; i < NCH; i++) if (mVal[i] == 0) anyZero = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        n = mVal[i] + int'(inc_amt[i*VW +: VW]) - int'(dec_amt[i*VW +: VW]) - int'(decay_en[i]);
        if (n < 0) n = 0;
        if (n > MAXV) n = MAXV;
        mVal[i] = n;
      end
      if (anyZero) begin
        mZero++;
        if (mZero >= ZERO_HOLD) mExp = 1'b1;
      end else begin
        mZero = 0;
      end
    end
    mPhase = (mPhase + 1) % TICK_DIV;
  endtask

  task automatic compareAll();
    for (int i = 0; i < NCH; i++) begin
      checkOutput($sformatf("value[%0d]", i), int'(value[i*VW +: VW]), mVal[i]);
      checkOutput($sformatf("level[%0d]", i), int'(level[i*LW +: LW]), mLvl[i]);
      checkOutput($sformatf("low_alarm[%0d]", i), int'(low_alarm[i]), int'(mAlarm[i]));
    end
    checkOutput("expired", int'(expired), int'(mExp));
    checkOutput("cmd_ready", int'(cmd_ready), (mPhase == TICK_DIV - 1) ? 0 : 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!mLastTick && n < TICK_DIV + 1);
    if (!mLastTick) begin
      checks++;
      $display("[TB] FAIL waitTick: no tick within %0d cycles", n);
    end
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [1:0] ch);
    int n;
    n = 0;
    cmd_op = op;
    cmd_ch = ch;
    cmd_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!mLastAcc && n < 4);
    cmd_valid = 1'b0;
    if (!mLastAcc) begin
      checks++;
      $display("[TB] FAIL issueCmd: not accepted within %0d cycles", n);
    end
  endtask

  function automatic logic [NCH*VW-1:0] chAmt(input int ch, input int amt);
    logic [NCH*VW-1:0] v;
    v = '0;
    v[ch*VW +: VW] = VW'(amt);
    return v;
  endfunction

  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < NCH; i++) begin
      checkOutput($sformatf("%s value[%0d]", tag, i), int'(value[i*VW +: VW]), 255);
      checkOutput($sformatf("%s level[%0d]", tag, i), int'(level[i*LW +: LW]), 5);
    end
    checkOutput({tag, " low_alarm"}, int'(low_alarm), 0);
    checkOutput({tag, " expired"}, int'(expired), 0);
    checkOutput({tag, " cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    logic [NCH*VW-1:0] incV;
    logic [NCH*VW-1:0] decV;
    int n;

    vecs[0] = '{decAmt: 28,  expVal: 52, expLvl: 2, expAlarm: 0};
    vecs[1] = '{decAmt: 29,  expVal: 51, expLvl: 1, expAlarm: 1};
    vecs[2] = '{decAmt: 79,  expVal: 1,  expLvl: 1, expAlarm: 1};
    vecs[3] = '{decAmt: 80,  expVal: 0,  expLvl: 0, expAlarm: 1};
    vecs[4] = '{decAmt: 200, expVal: 0,  expLvl: 0, expAlarm: 1};

    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_ch = 2'd0;
    resetModel();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Natural decay on all channels
    applyStimulus(3'b111, '0, '0, 1'b0);
    repeat (4) cycle();
    checkOutput("decay first tick value0", int'(value[0 +: VW]), 254);
    checkOutput("decay first tick level0", int'(level[0 +: LW]), 5);
    repeat (51 * TICK_DIV) cycle();
    checkOutput("decay 52 ticks value0", int'(value[0 +: VW]), 203);
    cycle();
    checkOutput("decay 52 ticks level0", int'(level[0 +: LW]), 4);

    // Saturation at both ends
    applyStimulus('0, '0, '0, 1'b0);
    issueCmd(2'd3, 2'd0);
    applyStimulus('0, chAmt(0, 8), '0, 1'b0);
    waitTick();
    checkOutput("sat high value0", int'(value[0 +: VW]), 255);
    applyStimulus('0, '0, '0, 1'b0);
    issueCmd(2'd1, 2'd1);
    applyStimulus('0, chAmt(1, 20), '0, 1'b0);
    waitTick();
    checkOutput("boost value1", int'(value[VW +: VW]), 100);
    applyStimulus('0, '0, chAmt(1, 200), 1'b0);
    waitTick();
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("sat low value1", int'(value[VW +: VW]), 0);
    cycle();
    checkOutput("sat low level1", int'(level[LW +: LW]), 0);
    checkOutput("sat low alarm1", int'(low_alarm[1]), 1);
    issueCmd(2'd0, 2'd0);

    // Level boundary table
    for (int v = 0; v < 5; v++) begin
      issueCmd(2'd1, 2'd0);
      applyStimulus('0, '0, chAmt(0, vecs[v].decAmt), 1'b0);
      waitTick();
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput($sformatf("vec%0d value0", v), int'(value[0 +: VW]), vecs[v].expVal);
      cycle();
      checkOutput($sformatf("vec%0d level0", v), int'(level[0 +: LW]), vecs[v].expLvl);
      checkOutput($sformatf("vec%0d alarm0", v), int'(low_alarm[0]), vecs[v].expAlarm);
    end
    issueCmd(2'd0, 2'd0);

    // Command raised on the tick cycle stalls for one cycle
    n = 0;
    while (mPhase != TICK_DIV - 1 && n < 8) begin
      cycle();
      n++;
    end
    cmd_op = 2'd1;
    cmd_ch = 2'd1;
    cmd_valid = 1'b1;
    checkOutput("stall cmd_ready", int'(cmd_ready), 0);
    cycle();
    checkOutput("stall value1 held", int'(value[VW +: VW]), 255);
    cycle();
    checkOutput("stall value1 accepted", int'(value[VW +: VW]), 80);
    cmd_valid = 1'b0;
    cycle();
    checkOutput("stall level1", int'(level[LW +: LW]), 2);
    issueCmd(2'd2, 2'd3);
    checkOutput("bad ch value0", int'(value[0 +: VW]), 255);
    checkOutput("bad ch value2", int'(value[2*VW +: VW]), 255);

    // Zero hold and expiry
    issueCmd(2'd0, 2'd0);
    issueCmd(2'd2, 2'd2);
    waitTick();
    waitTick();
    checkOutput("zero 2 ticks expired", int'(expired), 0);
    waitTick();
    checkOutput("zero 3 ticks expired", int'(expired), 1);
    issueCmd(2'd0, 2'd0);
    checkOutput("op00 expired", int'(expired), 0);
    for (int i = 0; i < NCH; i++)
      checkOutput($sformatf("op00 value[%0d]", i), int'(value[i*VW +: VW]), 255);
    issueCmd(2'd2, 2'd2);
    waitTick();
    waitTick();
    issueCmd(2'd3, 2'd2);
    repeat (3) waitTick();
    checkOutput("zero left early expired", int'(expired), 0);

    // Freeze holds values and the zero timer; commands still honoured
    issueCmd(2'd2, 2'd2);
    waitTick();
    waitTick();
    applyStimulus(3'b111, '0, '0, 1'b1);
    repeat (8) waitTick();
    checkOutput("freeze value0", int'(value[0 +: VW]), 255);
    checkOutput("freeze expired", int'(expired), 0);
    issueCmd(2'd1, 2'd0);
    checkOutput("freeze cmd value0", int'(value[0 +: VW]), 80);
    applyStimulus('0, '0, '0, 1'b0);
    waitTick();
    checkOutput("unfreeze expired", int'(expired), 1);
    issueCmd(2'd0, 2'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      incV = '0;
      decV = '0;
      for (int i = 0; i < NCH; i++) begin
        incV[i*VW +: VW] = VW'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6));
        decV[i*VW +: VW] = VW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8));
      end
      applyStimulus(NCH'($urandom_range(0, 7)), incV, decV, ($urandom_range(0, 9) == 0));
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      cmd_ch = 2'($urandom_range(0, 3));
      cycle();
    end
    cmd_valid = 1'b0;

    // Asynchronous reset mid-run with a pending command and expired set
    applyStimulus('0, '0, '0, 1'b0);
    issueCmd(2'd0, 2'd0);
    issueCmd(2'd2, 2'd0);
    repeat (3) waitTick();
    checkOutput("pre-reset expired", int'(expired), 1);
    applyStimulus(3'b111, '0, '0, 1'b0);
    cmd_op = 2'd2;
    cmd_ch = 2'd1;
    cmd_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midrun reset");
    resetModel();
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    checkOutput("post-reset phase value0", int'(value[0 +: VW]), 255);
    cycle();
    checkOutput("post-reset first tick value0", int'(value[0 +: VW]), 254);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
